// File: rtl/spu_pkg.sv
// rtl/spu_pkg.sv - shared scoreboard entry type and default SPU issue-stage parameters
package spu_pkg;

   localparam int LANES_DEF    = 2;
   localparam int SRCS_DEF     = 3;
   localparam int DEPTH_DEF    = 8;
   localparam int ADDR_W_DEF   = 7;
   localparam int BR_STAGE_DEF = 3;

   // Entry fields are sized for the widest supported configuration; narrower
   // register files are zero-extended on the way in.
   localparam int SB_ADDR_MAX  = 16;
   localparam int SB_REM_MAX   = 8;

   typedef logic [SB_ADDR_MAX-1:0] sb_addr_t;
   typedef logic [SB_REM_MAX-1:0]  sb_rem_t;

   typedef struct packed {
      logic     valid;
      sb_addr_t addr;
      logic     write;
      sb_rem_t  rem;
   } sb_entry_t;

   function automatic sb_rem_t rem_dec(input sb_rem_t r);
      return (r == '0) ? '0 : r - sb_rem_t'(1);
   endfunction

endpackage

// File: rtl/sb_match.sv
// rtl/sb_match.sv - youngest-match priority search for one source operand
module sb_match
   import spu_pkg::*;
#(
   parameter int LANES   = LANES_DEF,
   parameter int DEPTH   = DEPTH_DEF,
   parameter int LANE_W  = 1,
   parameter int STAGE_W = 3
)(
   input  sb_entry_t [DEPTH-1:0][LANES-1:0] entries,
   input  sb_addr_t                         src_addr,
   input  logic                             src_used,
   output logic                             hit,
   output logic                             ready,
   output logic [LANE_W-1:0]                lane,
   output logic [STAGE_W-1:0]               stage
);

   // Scan oldest to youngest so the last match written is the winner:
   // lowest stage first, then highest lane within that stage.
   always_comb begin
      hit   = 1'b0;
      ready = 1'b0;
      lane  = '0;
      stage = '0;
      for (int k = DEPTH-1; k >= 0; k--) begin
         for (int l = 0; l < LANES; l++) begin
            if (src_used && entries[k][l].valid && entries[k][l].write &&
                entries[k][l].addr == src_addr) begin
               hit   = 1'b1;
               ready = (entries[k][l].rem == '0);
               lane  = LANE_W'(l);
               stage = STAGE_W'(k);
            end
         end
      end
   end

endmodule

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - RAW-hazard scoreboard, forward select and retire strobes for the SPU issue stage
module issue_scoreboard
   import spu_pkg::*;
#(
   parameter int  LANES    = LANES_DEF,
   parameter int  SRCS     = SRCS_DEF,
   parameter int  DEPTH    = DEPTH_DEF,
   parameter int  ADDR_W   = ADDR_W_DEF,
   parameter int  BR_STAGE = BR_STAGE_DEF,
   localparam int LAT_W    = $clog2(DEPTH+1),
   localparam int LANE_W   = (LANES > 1) ? $clog2(LANES) : 1,
   localparam int STAGE_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic [LANES-1:0]                            issue_valid,
   input  logic [LANES-1:0][ADDR_W-1:0]                rt_addr,
   input  logic [LANES-1:0]                            reg_write,
   input  logic [LANES-1:0][LAT_W-1:0]                 latency,
   input  logic [LANES-1:0][SRCS-1:0][ADDR_W-1:0]      src_addr,
   input  logic [LANES-1:0][SRCS-1:0]                  src_used,
   input  logic                                        flush,
   input  logic [LANE_W-1:0]                           flush_lane,
   output logic [LANES-1:0]                            issue_ack,
   output logic [LANES-1:0][SRCS-1:0]                  fwd_hit,
   output logic [LANES-1:0][SRCS-1:0][LANE_W-1:0]      fwd_lane,
   output logic [LANES-1:0][SRCS-1:0][STAGE_W-1:0]     fwd_stage,
   output logic [LANES-1:0]                            wb_valid,
   output logic [LANES-1:0][ADDR_W-1:0]                wb_addr
);

   sb_entry_t [DEPTH-1:0][LANES-1:0]        sb_q;
   sb_entry_t [DEPTH-1:0][LANES-1:0]        sb_d;

   sb_addr_t  [LANES-1:0][SRCS-1:0]         src_wide;
   sb_addr_t  [LANES-1:0]                   rt_wide;

   logic      [LANES-1:0][SRCS-1:0]         m_hit;
   logic      [LANES-1:0][SRCS-1:0]         m_ready;
   logic      [LANES-1:0][SRCS-1:0][LANE_W-1:0]  m_lane;
   logic      [LANES-1:0][SRCS-1:0][STAGE_W-1:0] m_stage;

   logic      [LANES-1:0]                   lane_hazard;

   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         rt_wide[l]              = '0;
         rt_wide[l][ADDR_W-1:0]  = rt_addr[l];
         for (int s = 0; s < SRCS; s++) begin
            src_wide[l][s]             = '0;
            src_wide[l][s][ADDR_W-1:0] = src_addr[l][s];
         end
      end
   end

   for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
      for (genvar gs = 0; gs < SRCS; gs++) begin : g_src
         sb_match #(
            .LANES   (LANES),
            .DEPTH   (DEPTH),
            .LANE_W  (LANE_W),
            .STAGE_W (STAGE_W)
         ) u_match (
            .entries  (sb_q),
            .src_addr (src_wide[gl][gs]),
            .src_used (src_used[gl][gs]),
            .hit      (m_hit[gl][gs]),
            .ready    (m_ready[gl][gs]),
            .lane     (m_lane[gl][gs]),
            .stage    (m_stage[gl][gs])
         );
      end
   end

   // Acceptance is an in-order prefix: the first valid lane that stalls
   // blocks every younger lane in the group.
   always_comb begin
      logic intra;
      logic prefix_ok;
      lane_hazard = '0;
      issue_ack   = '0;
      intra       = 1'b0;
      prefix_ok   = !flush;
      for (int l = 0; l < LANES; l++) begin
         for (int s = 0; s < SRCS; s++) begin
            intra = 1'b0;
            for (int j = 0; j < l; j++) begin
               if (issue_valid[j] && reg_write[j] && src_used[l][s] &&
                   rt_addr[j] == src_addr[l][s])
                  intra = 1'b1;
            end
            if ((m_hit[l][s] && !m_ready[l][s]) || intra)
               lane_hazard[l] = 1'b1;
         end
         issue_ack[l] = prefix_ok && issue_valid[l] && !lane_hazard[l];
         if (issue_valid[l] && !issue_ack[l])
            prefix_ok = 1'b0;
      end
   end

   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         for (int s = 0; s < SRCS; s++) begin
            fwd_hit[l][s]   = m_hit[l][s] && m_ready[l][s];
            fwd_lane[l][s]  = fwd_hit[l][s] ? m_lane[l][s]  : '0;
            fwd_stage[l][s] = fwd_hit[l][s] ? m_stage[l][s] : '0;
         end
      end
   end

   // Flush kills wrong-path entries before the shift: everything younger
   // than the branch stage, plus younger lanes of the branch's own group.
   always_comb begin
      sb_entry_t e;
      e    = '0;
      sb_d = '0;
      for (int k = 1; k < DEPTH; k++) begin
         for (int l = 0; l < LANES; l++) begin
            e = sb_q[k-1][l];
            if (flush && ((k-1) < BR_STAGE ||
                          ((k-1) == BR_STAGE && l > int'(flush_lane))))
               e = '0;
            e.rem      = rem_dec(e.rem);
            sb_d[k][l] = e;
         end
      end
      for (int l = 0; l < LANES; l++) begin
         if (issue_ack[l]) begin
            sb_d[0][l].valid = 1'b1;
            sb_d[0][l].addr  = rt_wide[l];
            sb_d[0][l].write = reg_write[l];
            if (latency[l] != '0)
               sb_d[0][l].rem[LAT_W-1:0] = latency[l] - LAT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         sb_q <= '0;
      else
         sb_q <= sb_d;
   end

   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         wb_valid[l] = sb_q[DEPTH-1][l].valid && sb_q[DEPTH-1][l].write;
         wb_addr[l]  = wb_valid[l] ? sb_q[DEPTH-1][l].addr[ADDR_W-1:0] : '0;
      end
   end

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Parametrised RAW-hazard scoreboard and forwarding-select generator for the multi-lane SPU issue stage. For every lane it tracks in-flight destination writes as a DEPTH-stage shift register. Each cycle it checks the incoming issue group's source operands against those writes and returns three things: an in-order accept mask (partial-group issue on hazard), per-operand forward selects, and retire strobes. Branch flushes invalidate wrong-path entries, including younger lanes in the branch's own group.

## Interface
- LANES, 2: issue lanes; lane index equals program order within a group (lane 0 oldest)
- SRCS, 3: source operands per lane
- DEPTH, 8: tracked pipeline stages (0..DEPTH-1)
- ADDR_W, 7: register address width
- BR_STAGE, 3: stage index at which branches resolve (must be < DEPTH)
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- issue_valid  input  [LANES]  lane holds a decoded instruction
- rt_addr  input  [LANES][ADDR_W]  destination register
- reg_write  input  [LANES]  instruction writes rt
- latency  input  [LANES][$clog2(DEPTH+1)]  cycles until result is forwardable, 1..DEPTH
- src_addr  input  [LANES][SRCS][ADDR_W]  source registers
- src_used  input  [LANES][SRCS]  operand is actually read
- flush  input  1  branch at stage BR_STAGE taken this cycle
- flush_lane  input  [$clog2(LANES)]  lane of the taken branch
- issue_ack  output  [LANES]  lane accepted this cycle (combinational)
- fwd_hit  output  [LANES][SRCS]  operand taken from forward network
- fwd_lane  output  [LANES][SRCS][$clog2(LANES)]  producing lane
- fwd_stage  output  [LANES][SRCS][$clog2(DEPTH)]  producing stage
- wb_valid  output  [LANES]  entry at stage DEPTH-1 retires with a write (registered)
- wb_addr  output  [LANES][ADDR_W]  its destination

## Operation
- Entry per (stage, lane): valid, addr, write, rem.
- Every cycle all entries shift stage k -> k+1; rem decrements, saturating at 0. Stage DEPTH-1 drops off.
- Stage 0 loads accepted lanes: valid=1, addr=rt_addr, write=reg_write, rem=latency-1. Unaccepted lanes load valid=0 (bubble).
- Match for operand (l,s): any valid, write=1 entry with addr==src_addr, with src_used=1.
- Youngest match wins: lowest stage first, then highest lane.
- Hazard: the youngest match has rem!=0.
- Intra-group RAW: lane j<l with issue_valid, reg_write and rt_addr==src_addr(l,s) is also a hazard for l.
- Acceptance: issue_ack[l]=1 iff issue_valid[l], no hazard on lanes 0..l, and all lower valid lanes are acked. The result is a prefix mask; the issue stage holds unacked lanes.
- fwd_hit/lane/stage come from the youngest match when rem==0. Otherwise they are 0 and the register table is used.
- Flush:
  - issue_ack forced to 0.
  - Stages 0..BR_STAGE-1 invalidated before shifting.
  - At stage BR_STAGE, lanes > flush_lane invalidated.
  - Remaining entries shift normally.
- A WAW pair in the same group is legal; the higher lane is the youngest.

## Timing
- Producer accepted in cycle T with latency L: a consumer is acked no earlier than cycle T+L. L=1 gives back-to-back forwarding.
- issue_ack and fwd_* are combinational from inputs plus current state; there are no registered issue outputs.
- wb_valid/wb_addr are registered; they reflect stage DEPTH-1 contents, which are still matchable during the same cycle.
- Reset (async): all entries invalid, rem=0, wb_valid=0, wb_addr=0. issue_ack then depends only on intra-group hazards.
- Reset mid-operation discards all in-flight state; no retire strobes are produced for discarded entries.
- Flush combined with issue_valid: the group is not accepted, and bubbles enter stage 0.

## Structure
- The shared package spu_pkg holds the entry struct (valid, addr, write, rem) and the default parameter constants.
- Sub-module sb_match (one instance per operand): priority search over DEPTH×LANES entries returning hit, lane, stage and ready.
- The top level holds the shift register, the acceptance prefix logic and the flush masking.

## Test plan
- Lane0 is accepted writing r5 with L=2, then next cycle lane0 reads r5. Required: ack=0 that cycle. On the following cycle: ack=1, fwd_hit=1, fwd_stage=1, fwd_lane=0.
- L=1 producer on r9, then lane1 reads r9 next cycle. Required: ack=2'b11, fwd_stage=0.
- Same group: lane0 writes r3, lane1 reads r3. Required: ack=2'b01; next cycle lane1 is re-presented with ack=1.
- Flush with flush_lane=0 while stage BR_STAGE holds r4 in lane0 and r6 in lane1, and stage 1 holds r7. Required: r6 and r7 never produce wb_valid; r4 retires DEPTH-1-BR_STAGE cycles later.
- Two producers of r2, in stages 1 and 4. Required: fwd_stage=1.
- Reset asserted with 5 valid entries. Required: wb_valid=0 immediately and at no later cycle for those entries; a post-reset read of r2 gives fwd_hit=0.
